intel_vvp_exposure_fusion_sched: RTL and testbench
==================================================

INTEL_VVP_EXPOSURE_FUSION_SCHED -- requirements
Module: intel_vvp_exposure_fusion_sched

Interface
REQ-001 Parameter C_GAP_TIMEOUT, default 4096, max main_clock cycles allowed between long-frame EOF and short-frame SOF.
REQ-002 Parameters C_OUTPUT_MODE, C_BLACK_LEVEL, C_EXPOSURE_RATIO, C_THRESHOLD, default 0 each; reset values of the active parameter set.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 main_clock  in  1  sole clock.
REQ-005 main_reset  in  1  synchronous active-high reset.
REQ-006 cfg_output_mode[1:0], cfg_black_level[15:0], cfg_exposure_ratio[16:0], cfg_threshold[15:0]  in  staged parameters, already in main_clock domain.
REQ-007 cfg_commit  in  1  single-cycle request to apply the staged set.
REQ-008 sof  in  1  start-of-frame pulse; frame_is_long  in  1  exposure tag, valid only with sof.
REQ-009 eof  in  1  end-of-frame pulse.
REQ-010 act_output_mode, act_black_level, act_exposure_ratio, act_threshold  out  2/16/17/16  parameters driven to the fusion datapath.
REQ-011 fuse_active  out  1  high while a long/short pair is in flight.
REQ-012 pair_done  out  1  one-cycle pulse at short-frame EOF.
REQ-013 commit_ack  out  1  one-cycle pulse in the cycle the active set is updated.
REQ-014 pair_err  out  1  sticky; cleared only by reset.

Function
REQ-015 The FSM SHALL have states IDLE, LONG, WAIT_SHORT and SHORT.
REQ-016 IDLE: on sof with frame_is_long=1 -> LONG; sof with frame_is_long=0 is ignored.
REQ-017 LONG: on eof -> WAIT_SHORT and load the gap counter with 0.
REQ-018 WAIT_SHORT: on sof with short tag -> SHORT; on sof with long tag -> set pair_err and go to LONG (new pair).
REQ-019 WAIT_SHORT: the gap counter increments each cycle; at C_GAP_TIMEOUT-1 without sof -> set pair_err and go to IDLE.
REQ-020 SHORT: on eof -> IDLE and pulse pair_done in that cycle.
REQ-021 An sof in LONG or SHORT (missing eof) SHALL set pair_err and be treated as an IDLE-state sof.
REQ-022 When eof and sof coincide, eof is processed first and sof is then evaluated against the resulting state in the same cycle (zero-gap back-to-back).
REQ-023 cfg_commit SHALL set a pending flag, and the staged inputs SHALL be captured into a shadow set in the same cycle; a later commit before apply overwrites the shadow.
REQ-024 With pending set, the shadow set SHALL be copied to act_* in the cycle a long-tagged sof is accepted from IDLE or WAIT_SHORT; commit_ack pulses, pending clears.
REQ-025 A cfg_commit coinciding with an accepting sof SHALL apply the new staged values immediately.
REQ-026 fuse_active = (state != IDLE), registered; act_* never change while fuse_active=1 except at an accepting sof.
REQ-027 Latency: all outputs SHALL be registered, with a one-cycle delay from the causing input pulse.

Reset
REQ-028 Reset SHALL produce state IDLE, pending=0, and act_* = C_* parameters.
REQ-029 Reset SHALL clear fuse_active, pair_done, commit_ack, pair_err and the gap counter.
REQ-030 Reset mid-pair SHALL abandon the pair without a pair_done pulse.

Configuration
REQ-031 With macro EXPOSURE_FUSION_SCHED_STATS_EN defined, the block SHALL add outputs stat_pairs[31:0] (pair_done count) and stat_errs[15:0] (pair_err events), both wrapping and cleared by reset.
REQ-032 Without EXPOSURE_FUSION_SCHED_STATS_EN, no counters or ports SHALL exist.

Structure
REQ-033 Package intel_vvp_exposure_fusion_pkg SHALL hold the OUTPUT_MODE_WIDTH, BPS_MAX and EXPOSURE_RATIO_WIDTH constants, the state enum, and the param_set_t struct.
REQ-034 There SHALL be no sub-modules; a single FSM plus counter.

Verification
REQ-035 Commit then long sof, eof, short sof, eof -> commit_ack at the long sof+1; pair_done once; act_* = staged values.
REQ-036 Commit during SHORT -> act_* unchanged until the next long sof; values applied there.
REQ-037 C_GAP_TIMEOUT=16, long eof then no sof for 16 cycles -> pair_err=1, state IDLE, fuse_active=0.
REQ-038 Long, eof, long sof -> pair_err=1, new pair proceeds, pair_done after the following short eof.
REQ-039 Same-cycle eof and short sof in LONG -> SHORT entered with no error.
REQ-040 Reset asserted in SHORT -> act_*=C_*, no pair_done; with STATS_EN, counters read 0.

Source files
------------

// File: rtl/intel_vvp_exposure_fusion_pkg.sv
// Shared constants, FSM state type and parameter-set layout for the exposure fusion scheduler.
package intel_vvp_exposure_fusion_pkg;

  localparam int unsigned OUTPUT_MODE_WIDTH    = 2;
  localparam int unsigned BPS_MAX              = 16;
  localparam int unsigned EXPOSURE_RATIO_WIDTH = 17;

  typedef enum logic [1:0] {
    StIdle,
    StLong,
    StWaitShort,
    StShort
  } sched_state_e;

  typedef struct packed {
    logic [OUTPUT_MODE_WIDTH-1:0]    output_mode;
    logic [BPS_MAX-1:0]              black_level;
    logic [EXPOSURE_RATIO_WIDTH-1:0] exposure_ratio;
    logic [BPS_MAX-1:0]              threshold;
  } param_set_t;

endpackage

// File: rtl/intel_vvp_exposure_fusion_sched_if.sv
// Config/frame-event/output bundle of the exposure fusion scheduler.
// Statistics signals exist only with EXPOSURE_FUSION_SCHED_STATS_EN defined.
interface intel_vvp_exposure_fusion_sched_if;
  import intel_vvp_exposure_fusion_pkg::*;

  logic [OUTPUT_MODE_WIDTH-1:0]    cfg_output_mode;
  logic [BPS_MAX-1:0]              cfg_black_level;
  logic [EXPOSURE_RATIO_WIDTH-1:0] cfg_exposure_ratio;
  logic [BPS_MAX-1:0]              cfg_threshold;
  logic                            cfg_commit;
  logic                            sof;
  logic                            frame_is_long;
  logic                            eof;

  logic [OUTPUT_MODE_WIDTH-1:0]    act_output_mode;
  logic [BPS_MAX-1:0]              act_black_level;
  logic [EXPOSURE_RATIO_WIDTH-1:0] act_exposure_ratio;
  logic [BPS_MAX-1:0]              act_threshold;
  logic                            fuse_active;
  logic                            pair_done;
  logic                            commit_ack;
  logic                            pair_err;

`ifdef EXPOSURE_FUSION_SCHED_STATS_EN
  logic [31:0] stat_pairs;
  logic [15:0] stat_errs;

  modport master (
    output cfg_output_mode, cfg_black_level, cfg_exposure_ratio, cfg_threshold, cfg_commit,
    output sof, frame_is_long, eof,
    input  act_output_mode, act_black_level, act_exposure_ratio, act_threshold,
    input  fuse_active, pair_done, commit_ack, pair_err, stat_pairs, stat_errs
  );

  modport slave (
    input  cfg_output_mode, cfg_black_level, cfg_exposure_ratio, cfg_threshold, cfg_commit,
    input  sof, frame_is_long, eof,
    output act_output_mode, act_black_level, act_exposure_ratio, act_threshold,
    output fuse_active, pair_done, commit_ack, pair_err, stat_pairs, stat_errs
  );
`else
  modport master (
    output cfg_output_mode, cfg_black_level, cfg_exposure_ratio, cfg_threshold, cfg_commit,
    output sof, frame_is_long, eof,
    input  act_output_mode, act_black_level, act_exposure_ratio, act_threshold,
    input  fuse_active, pair_done, commit_ack, pair_err
  );

  modport slave (
    input  cfg_output_mode, cfg_black_level, cfg_exposure_ratio, cfg_threshold, cfg_commit,
    input  sof, frame_is_long, eof,
    output act_output_mode, act_black_level, act_exposure_ratio, act_threshold,
    output fuse_active, pair_done, commit_ack, pair_err
  );
`endif

endinterface

// File: rtl/intel_vvp_exposure_fusion_sched.sv
// Long/short exposure pair scheduler with frame-aligned parameter commit.
// Optional pair/error counters enabled by EXPOSURE_FUSION_SCHED_STATS_EN.
module intel_vvp_exposure_fusion_sched
  import intel_vvp_exposure_fusion_pkg::*;
#(
  parameter int unsigned                     C_GAP_TIMEOUT    = 4096,
  parameter logic [OUTPUT_MODE_WIDTH-1:0]    C_OUTPUT_MODE    = '0,
  parameter logic [BPS_MAX-1:0]              C_BLACK_LEVEL    = '0,
  parameter logic [EXPOSURE_RATIO_WIDTH-1:0] C_EXPOSURE_RATIO = '0,
  parameter logic [BPS_MAX-1:0]              C_THRESHOLD      = '0
) (
  input logic                              main_clock,
  input logic                              main_reset,
  intel_vvp_exposure_fusion_sched_if.slave bus
);

  localparam int unsigned     GapW     = (C_GAP_TIMEOUT > 1) ? $clog2(C_GAP_TIMEOUT) : 1;
  localparam logic [GapW-1:0] GapLast  = GapW'(C_GAP_TIMEOUT - 1);
  localparam param_set_t      ResetSet = '{
    output_mode:    C_OUTPUT_MODE,
    black_level:    C_BLACK_LEVEL,
    exposure_ratio: C_EXPOSURE_RATIO,
    threshold:      C_THRESHOLD
  };

  sched_state_e    state_q, state_d, mid_state;
  logic [GapW-1:0] gap_q, gap_d;
  param_set_t      staged, shadow_q, act_q, act_d;
  logic            pending_q, pending_d;
  logic            pair_done_q, pair_done_d;
  logic            commit_ack_q, commit_ack_d;
  logic            pair_err_q, pair_err_d;
  logic            err_event, accept;

  assign staged = '{
    output_mode:    bus.cfg_output_mode,
    black_level:    bus.cfg_black_level,
    exposure_ratio: bus.cfg_exposure_ratio,
    threshold:      bus.cfg_threshold
  };

  always_comb begin
    mid_state   = state_q;
    state_d     = state_q;
    gap_d       = gap_q;
    pair_done_d = 1'b0;
    err_event   = 1'b0;
    accept      = 1'b0;

    // eof resolves first so a coincident sof sees the post-eof state.
    if (bus.eof) begin
      unique case (state_q)
        StLong: begin
          mid_state = StWaitShort;
          gap_d     = '0;
        end
        StShort: begin
          mid_state   = StIdle;
          pair_done_d = 1'b1;
        end
        default: ;
      endcase
    end
    state_d = mid_state;

    if (bus.sof) begin
      unique case (mid_state)
        StIdle: begin
          if (bus.frame_is_long) begin
            state_d = StLong;
            accept  = 1'b1;
          end
        end
        StWaitShort: begin
          if (bus.frame_is_long) begin
            err_event = 1'b1;
            state_d   = StLong;
            accept    = 1'b1;
          end else begin
            state_d = StShort;
          end
        end
        default: begin
          // Missing eof: flag it and restart as if the sof arrived in idle.
          err_event = 1'b1;
          state_d   = bus.frame_is_long ? StLong : StIdle;
          accept    = bus.frame_is_long;
        end
      endcase
    end else if (state_q == StWaitShort && mid_state == StWaitShort) begin
      if (gap_q == GapLast) begin
        err_event = 1'b1;
        state_d   = StIdle;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
  end

  always_comb begin
    pending_d    = pending_q | bus.cfg_commit;
    act_d        = act_q;
    commit_ack_d = 1'b0;
    pair_err_d   = pair_err_q | err_event;
    if (accept && pending_d) begin
      act_d        = bus.cfg_commit ? staged : shadow_q;
      commit_ack_d = 1'b1;
      pending_d    = 1'b0;
    end
  end

  always_ff @(posedge main_clock) begin
    if (main_reset) begin
      state_q      <= StIdle;
      gap_q        <= '0;
      shadow_q     <= ResetSet;
      act_q        <= ResetSet;
      pending_q    <= 1'b0;
      pair_done_q  <= 1'b0;
      commit_ack_q <= 1'b0;
      pair_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      act_q        <= act_d;
      pending_q    <= pending_d;
      pair_done_q  <= pair_done_d;
      commit_ack_q <= commit_ack_d;
      pair_err_q   <= pair_err_d;
      if (bus.cfg_commit) begin
        shadow_q <= staged;
      end
    end
  end

  assign bus.act_output_mode    = act_q.output_mode;
  assign bus.act_black_level    = act_q.black_level;
  assign bus.act_exposure_ratio = act_q.exposure_ratio;
  assign bus.act_threshold      = act_q.threshold;
  assign bus.fuse_active        = (state_q != StIdle);
  assign bus.pair_done          = pair_done_q;
  assign bus.commit_ack         = commit_ack_q;
  assign bus.pair_err           = pair_err_q;

`ifdef EXPOSURE_FUSION_SCHED_STATS_EN
  logic [31:0] stat_pairs_q;
  logic [15:0] stat_errs_q;

  always_ff @(posedge main_clock) begin
    if (main_reset) begin
      stat_pairs_q <= '0;
      stat_errs_q  <= '0;
    end else begin
      if (pair_done_d) begin
        stat_pairs_q <= stat_pairs_q + 32'd1;
      end
      if (err_event) begin
        stat_errs_q <= stat_errs_q + 16'd1;
      end
    end
  end

  assign bus.stat_pairs = stat_pairs_q;
  assign bus.stat_errs  = stat_errs_q;
`endif

endmodule

// File: tb/tb_intel_vvp_exposure_fusion_sched.sv
// Scoreboard bench for the exposure fusion scheduler: expected commit_ack/pair_done events are
// queued as stimulus is driven and matched when the outputs pulse.
module tb_intel_vvp_exposure_fusion_sched;
  import intel_vvp_exposure_fusion_pkg::*;

  typedef struct {
    int         cyc;
    param_set_t p;
  } exp_ack_t;

  localparam param_set_t CSet = '{2'd1, 16'h0040, 17'h10000, 16'h0F00};

  logic main_clock = 1'b0;
  logic main_reset;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  exp_ack_t ack_q[$];
  int       done_q[$];

  param_set_t set_a, set_b, set_c, set_d;

  intel_vvp_exposure_fusion_sched_if bus ();

  intel_vvp_exposure_fusion_sched #(
    .C_GAP_TIMEOUT   (16),
    .C_OUTPUT_MODE   (CSet.output_mode),
    .C_BLACK_LEVEL   (CSet.black_level),
    .C_EXPOSURE_RATIO(CSet.exposure_ratio),
    .C_THRESHOLD     (CSet.threshold)
  ) dut (
    .main_clock(main_clock),
    .main_reset(main_reset),
    .bus       (bus)
  );

  always #5 main_clock = ~main_clock;

  always @(posedge main_clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic param_set_t act_now();
    return '{bus.act_output_mode, bus.act_black_level, bus.act_exposure_ratio, bus.act_threshold};
  endfunction

  task automatic set_staged(input param_set_t p);
    bus.cfg_output_mode    = p.output_mode;
    bus.cfg_black_level    = p.black_level;
    bus.cfg_exposure_ratio = p.exposure_ratio;
    bus.cfg_threshold      = p.threshold;
  endtask

  // One clock of stimulus; returns at the following negedge with outputs settled.
  task automatic drive(input logic s, input logic l, input logic e, input logic c);
    bus.sof           = s;
    bus.frame_is_long = l;
    bus.eof           = e;
    bus.cfg_commit    = c;
    @(negedge main_clock);
    bus.sof           = 1'b0;
    bus.frame_is_long = 1'b0;
    bus.eof           = 1'b0;
    bus.cfg_commit    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic exp_ack(input param_set_t p);
    exp_ack_t e;
    e.cyc = cyc + 1;
    e.p   = p;
    ack_q.push_back(e);
  endtask

  task automatic exp_done();
    done_q.push_back(cyc + 1);
  endtask

  task automatic do_reset();
    main_reset = 1'b1;
    @(negedge main_clock);
    @(negedge main_clock);
    main_reset = 1'b0;
  endtask

  always @(negedge main_clock) begin
    exp_ack_t e;
    int       d;
    if (!main_reset && bus.commit_ack) begin
      if (ack_q.size() == 0) begin
        check("ack_unexpected", 64'(bus.commit_ack), 64'd0);
      end else begin
        e = ack_q.pop_front();
        check("ack_cycle", 64'(cyc), 64'(e.cyc));
        check("ack_act", 64'(act_now()), 64'(e.p));
      end
    end
    if (!main_reset && bus.pair_done) begin
      if (done_q.size() == 0) begin
        check("done_unexpected", 64'(bus.pair_done), 64'd0);
      end else begin
        d = done_q.pop_front();
        check("done_cycle", 64'(cyc), 64'(d));
      end
    end
  end

  initial begin
    set_a = '{2'd2, 16'h0100, 17'h08000, 16'h1234};
    set_b = '{2'd3, 16'h0200, 17'h18000, 16'h2222};
    set_c = '{2'd0, 16'h0010, 17'h04000, 16'h0ABC};
    set_d = '{2'd2, 16'h0FFF, 17'h1FFFF, 16'hFFFF};
    set_staged('0);
    bus.sof           = 1'b0;
    bus.frame_is_long = 1'b0;
    bus.eof           = 1'b0;
    bus.cfg_commit    = 1'b0;
    @(negedge main_clock);
    do_reset();

    check("rst_act", 64'(act_now()), 64'(CSet));
    check("rst_fuse", 64'(bus.fuse_active), 64'd0);
    check("rst_done", 64'(bus.pair_done), 64'd0);
    check("rst_ack", 64'(bus.commit_ack), 64'd0);
    check("rst_err", 64'(bus.pair_err), 64'd0);

    // Commit in idle, applied at the long sof.
    set_staged(set_a);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("s1_act_held", 64'(act_now()), 64'(CSet));
    exp_ack(set_a);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("s1_fuse_on", 64'(bus.fuse_active), 64'd1);
    idle(2);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("s1_fuse_wait", 64'(bus.fuse_active), 64'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    exp_done();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("s1_fuse_off", 64'(bus.fuse_active), 64'd0);
    check("s1_err", 64'(bus.pair_err), 64'd0);
    check("s1_act", 64'(act_now()), 64'(set_a));

    // Commit during SHORT waits for the next long sof.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    set_staged(set_b);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    check("s2_act_held", 64'(act_now()), 64'(set_a));
    exp_done();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    check("s2_act_idle", 64'(act_now()), 64'(set_a));
    exp_ack(set_b);
    drive(1'b1, 1'b1, 1'b0, 1'b0);

    // Zero-gap eof + short sof in LONG.
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    check("s3_fuse", 64'(bus.fuse_active), 64'd1);
    check("s3_err", 64'(bus.pair_err), 64'd0);
    exp_done();
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // Commit coinciding with the accepting sof applies the live staged values.
    set_staged(set_c);
    exp_ack(set_c);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    check("s4_act", 64'(act_now()), 64'(set_c));
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);

    // Short eof with next long sof in the same cycle.
    exp_done();
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    check("s5_fuse", 64'(bus.fuse_active), 64'd1);
    check("s5_err", 64'(bus.pair_err), 64'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    exp_done();
    drive(1'b0, 1'b0, 1'b1, 1'b0);

    // Gap timeout after 16 silent cycles.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(15);
    check("s6_fuse_pre", 64'(bus.fuse_active), 64'd1);
    check("s6_err_pre", 64'(bus.pair_err), 64'd0);
    idle(1);
    check("s6_err", 64'(bus.pair_err), 64'd1);
    check("s6_fuse", 64'(bus.fuse_active), 64'd0);

    // Long sof where the short was expected restarts the pair.
    do_reset();
    check("s7_err_clr", 64'(bus.pair_err), 64'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    check("s7_err", 64'(bus.pair_err), 64'd1);
    check("s7_fuse", 64'(bus.fuse_active), 64'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    exp_done();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    check("s7_fuse_off", 64'(bus.fuse_active), 64'd0);
    // Missing eof in LONG: short sof drops back to idle.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("s7_miss_fuse", 64'(bus.fuse_active), 64'd0);
`ifdef EXPOSURE_FUSION_SCHED_STATS_EN
    check("s7_stat_pairs", 64'(bus.stat_pairs), 64'd1);
    check("s7_stat_errs", 64'(bus.stat_errs), 64'd2);
`endif

    // Reset in SHORT abandons the pair.
    do_reset();
    set_staged(set_d);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    exp_ack(set_d);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    check("s8_fuse_short", 64'(bus.fuse_active), 64'd1);
    check("s8_act_d", 64'(act_now()), 64'(set_d));
    do_reset();
    check("s8_act", 64'(act_now()), 64'(CSet));
    check("s8_fuse", 64'(bus.fuse_active), 64'd0);
    check("s8_err", 64'(bus.pair_err), 64'd0);
    check("s8_done", 64'(bus.pair_done), 64'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    idle(2);
    check("s8_fuse_post", 64'(bus.fuse_active), 64'd0);
`ifdef EXPOSURE_FUSION_SCHED_STATS_EN
    check("s8_stat_pairs", 64'(bus.stat_pairs), 64'd0);
    check("s8_stat_errs", 64'(bus.stat_errs), 64'd0);
`endif

    check("ack_drain", 64'(ack_q.size()), 64'd0);
    check("done_drain", 64'(done_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
